arith_unit_seq: RTL and testbench
=================================

Name: arith_unit_seq

Overview:
Parametrised multi-cycle integer arithmetic unit.
- ADD and SUB complete in one cycle.
- MULT uses iterative shift-add; DIV uses restoring division. Both produce HI/LO register results.
- Replaces the fixed 32-bit adder-based unit in the execute stage.
- Adds a start/busy/done handshake, divide-by-zero detection and a width parameter.

Parameters:
WIDTH, 32, operand/result width in bits (>=4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous reset, active-high.
start  input  1  request; accepted only when busy=0.
op  input  2  00 ADD, 01 SUB, 10 MULT, 11 DIV; sampled with start.
a  input  WIDTH  operand A / dividend; sampled with start.
b  input  WIDTH  operand B / divisor; sampled with start.
busy  output  1  iterative op in progress.
done  output  1  one-cycle pulse; results valid.
s  output  WIDTH  ADD/SUB result.
hi  output  WIDTH  MULT upper product / DIV remainder.
lo  output  WIDTH  MULT lower product / DIV quotient.
zero  output  1  zero flag of last completed op.
dbz  output  1  last completed op was DIV with b==0.

Behaviour:
- Reset: rst_n is asynchronous, active-high; clock is clk.
  - Reset clears all outputs to 0, the FSM to IDLE and all internal operand/accumulator registers.
  - Reset mid-operation aborts the operation. No done pulse is produced and hi/lo stay 0.
- FSM states: IDLE, MUL, DIV.
  - Accept condition in cycle T: state=IDLE and start=1.
  - start while busy=1 is ignored; it is not queued.
- ADD/SUB:
  - s <= a + b, or a + ~b + 1, modulo 2^WIDTH.
  - done=1 in T+1. busy stays 0. hi, lo and dbz are unchanged.
  - zero = (s==0).
- MULT:
  - Unsigned operands.
  - IDLE->MUL: load multiplicand, multiplier and a 2*WIDTH accumulator; cnt=0; busy=1 in T+1.
  - One shift-add iteration per cycle during T+1..T+WIDTH.
  - At the edge ending T+WIDTH: {hi,lo} <= accumulator, state->IDLE, busy->0, done=1 in T+WIDTH+1.
  - zero = ({hi,lo}==0). dbz=0.
- DIV:
  - Unsigned restoring division: shift remainder left, trial subtract, restore if negative, quotient bit = not negative.
  - Same timing as MULT: busy T+1..T+WIDTH, done in T+WIDTH+1.
  - Result: hi=remainder, lo=quotient. zero = (lo==0). dbz=0.
- Divide by zero (b==0 at accept):
  - No iteration is performed. done in T+1.
  - hi=a, lo=all-ones, dbz=1, zero=0.
- hi/lo are only written on MULT/DIV completion. Intermediate values never appear on the ports. s is only written on ADD/SUB completion.
- Back-to-back operation: start is accepted in the same cycle done=1, since the FSM is already IDLE.
- The counter saturates at WIDTH. No wrap-around is possible.

Optional Feature:
Macro ARITH_SIGNED_MULDIV_EN.
- Defined:
  - Adds input port sgn (1 bit), sampled with start.
  - When sgn=1, MULT and DIV treat a and b as two's complement. The unit takes absolute values, runs the unsigned core, then negates the results:
    - product negated if signs differ;
    - quotient negated if signs differ;
    - remainder takes the sign of the dividend.
  - Most-negative / -1 yields lo = most-negative and hi=0, with no trap.
  - Adds one cycle of latency for signed ops only: done in T+WIDTH+2.
- Not defined:
  - Port sgn is absent. All MULT/DIV are unsigned with the timing above.

Decomposition:
- Package arith_pkg holds:
  - op_e enum (OP_ADD, OP_SUB, OP_MULT, OP_DIV);
  - state_e enum (IDLE, MUL, DIV);
  - localparam defaults for WIDTH.
- One natural sub-module: arith_iter_step.
  - Combinational single iteration.
  - Mode select for shift-add vs. restore-subtract.
  - Inputs: accumulator and operand. Outputs: next accumulator and quotient bit.
  - Instantiated once; the top holds the FSM, counter and registers.

Test Plan:
1. ADD a=7, b=5 at T -> s=12, zero=0, done=1 at T+1 only, busy never 1.
2. SUB a=5, b=5 -> s=0, zero=1; then SUB a=0, b=1 -> s=0xFFFFFFFF, zero=0.
3. MULT a=0xFFFFFFFF, b=2 -> busy T+1..T+32, done at T+33, hi=0x00000001, lo=0xFFFFFFFE; start pulsed at T+5 is ignored.
4. DIV a=100, b=7 -> hi=2, lo=14, dbz=0 at T+33; immediate back-to-back DIV a=6, b=7 in the done cycle -> hi=6, lo=0, zero=1.
5. DIV a=0x1234, b=0 -> done at T+1, hi=0x1234, lo=0xFFFFFFFF, dbz=1, zero=0.
6. Reset asserted at T+10 of MULT 3*4 -> all outputs 0, busy=0 immediately, no done; next MULT 3*4 -> lo=12, hi=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types for the multi-cycle arithmetic unit: operation codes, FSM states
// and the default datapath width.
package arith_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULT = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/arith_iter_step.sv
// One combinational iteration of either shift-add multiply or restoring divide
// on a {upper, lower} double-width accumulator.
module arith_iter_step
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic                 qbit_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] rem_nx;
  logic             trial_neg;

  // Multiply: lower half holds the remaining multiplier bits, product grows from the top.
  assign mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

  // Divide: pull the next dividend bit into the partial remainder and trial-subtract.
  assign rem_sh    = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
  assign trial_neg = (rem_sh < {1'b0, opnd_i});
  assign rem_diff  = rem_sh[WIDTH-1:0] - opnd_i;
  assign rem_nx    = trial_neg ? rem_sh[WIDTH-1:0] : rem_diff;

  always_comb begin
    qbit_o = ~trial_neg;
    if (div_mode) begin
      // LSB left clear; the caller inserts the quotient bit.
      acc_o = {rem_nx, acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/arith_unit_seq.sv
// Multi-cycle integer unit: single-cycle ADD/SUB, iterative MULT/DIV with HI/LO results.
// Optional signed MULT/DIV enabled by defining ARITH_SIGNED_MULDIV_EN.
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ARITH_SIGNED_MULDIV_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   s_q, s_d, hi_q, hi_d, lo_q, lo_d;
  logic               zero_q, zero_d, dbz_q, dbz_d, done_q, done_d, busy_q, busy_d;

  logic [WIDTH-1:0]   a_u, b_u, sum_w, dif_w;
  logic [2*WIDTH-1:0] step_acc, step_full;
  logic               step_qbit;
  logic               sgn_run, neg_res, neg_rem;

`ifdef ARITH_SIGNED_MULDIV_EN
  logic sgn_q, sgn_d, nres_q, nres_d, nrem_q, nrem_d;
  logic a_neg, b_neg;

  // Signed ops run the unsigned core on magnitudes and fix signs in one extra cycle.
  assign a_neg   = sgn & a[WIDTH-1];
  assign b_neg   = sgn & b[WIDTH-1];
  assign a_u     = a_neg ? -a : a;
  assign b_u     = b_neg ? -b : b;
  assign sgn_run = sgn_q;
  assign neg_res = nres_q;
  assign neg_rem = nrem_q;
`else
  assign a_u     = a;
  assign b_u     = b;
  assign sgn_run = 1'b0;
  assign neg_res = 1'b0;
  assign neg_rem = 1'b0;
`endif

  assign sum_w = a + b;
  assign dif_w = a + ~b + 1'b1;

  arith_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state_q == DIV),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .qbit_o   (step_qbit)
  );

  assign step_full = {step_acc[2*WIDTH-1:1], (state_q == DIV) ? step_qbit : step_acc[0]};

  always_comb begin
    logic [2*WIDTH-1:0] fin_src;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               last;

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    s_d     = s_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
`ifdef ARITH_SIGNED_MULDIV_EN
    sgn_d   = sgn_q;
    nres_d  = nres_q;
    nrem_d  = nrem_q;
`endif
    fin_src = (cnt_q == CNT_MAX) ? acc_q : step_full;
    prod    = neg_res ? -fin_src : fin_src;
    quo     = neg_res ? -fin_src[WIDTH-1:0] : fin_src[WIDTH-1:0];
    rem     = neg_rem ? -fin_src[2*WIDTH-1:WIDTH] : fin_src[2*WIDTH-1:WIDTH];
    last    = (cnt_q == CNT_MAX) || ((cnt_q == CNT_LAST) && !sgn_run);

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ARITH_SIGNED_MULDIV_EN
          sgn_d  = sgn;
          nres_d = a_neg ^ b_neg;
          nrem_d = a_neg;
`endif
          case (op_e'(op))
            OP_ADD: begin
              s_d    = sum_w;
              zero_d = (sum_w == '0);
              done_d = 1'b1;
            end
            OP_SUB: begin
              s_d    = dif_w;
              zero_d = (dif_w == '0);
              done_d = 1'b1;
            end
            OP_MULT: begin
              acc_d   = {{WIDTH{1'b0}}, b_u};
              opnd_d  = a_u;
              cnt_d   = '0;
              state_d = MUL;
            end
            OP_DIV: begin
              if (b == '0) begin
                hi_d   = a;
                lo_d   = '1;
                dbz_d  = 1'b1;
                zero_d = 1'b0;
                done_d = 1'b1;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, a_u};
                opnd_d  = b_u;
                cnt_d   = '0;
                state_d = DIV;
              end
            end
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        // Counter stops at WIDTH; the extra cycle there is the signed fix-up.
        if (cnt_q != CNT_MAX) begin
          acc_d = step_full;
          cnt_d = cnt_q + 1'b1;
        end
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          dbz_d   = 1'b0;
          if (state_q == MUL) begin
            {hi_d, lo_d} = prod;
            zero_d       = (prod == '0);
          end else begin
            hi_d   = rem;
            lo_d   = quo;
            zero_d = (quo == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      s_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ARITH_SIGNED_MULDIV_EN
      sgn_q   <= 1'b0;
      nres_q  <= 1'b0;
      nrem_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      s_q     <= s_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef ARITH_SIGNED_MULDIV_EN
      sgn_q   <= sgn_d;
      nres_q  <= nres_d;
      nrem_q  <= nrem_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign zero = zero_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_arith_unit_seq.sv
// Bench for arith_unit_seq: directed steps then random ops against an arithmetic model.
module tb_arith_unit_seq;

  localparam int W = 32;

  logic         clk, rst_n, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, dbz;
  logic [W-1:0] s, hi, lo;

  int           pass_cnt = 0;
  int           tot_cnt  = 0;
  logic [W-1:0] e_s, e_hi, e_lo;
  logic         e_zero, e_dbz;
  int           e_lat;

  arith_unit_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef ARITH_SIGNED_MULDIV_EN
    .sgn   (1'b0),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .hi    (hi),
    .lo    (lo),
    .zero  (zero),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    case (o)
      2'b00: begin e_s = x + y; e_zero = (e_s == 0); e_lat = 0; end
      2'b01: begin e_s = x - y; e_zero = (e_s == 0); e_lat = 0; end
      2'b10: begin
        p = {32'd0, x} * {32'd0, y};
        e_hi = p[63:32]; e_lo = p[31:0]; e_zero = (p == 0); e_dbz = 1'b0; e_lat = W;
      end
      default: begin
        if (y == 0) begin
          e_hi = x; e_lo = '1; e_dbz = 1'b1; e_zero = 1'b0; e_lat = 0;
        end else begin
          e_hi = x % y; e_lo = x / y; e_zero = (e_lo == 0); e_dbz = 1'b0; e_lat = W;
        end
      end
    endcase
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_s"},    s,    e_s);
    chk({tag, "_hi"},   hi,   e_hi);
    chk({tag, "_lo"},   lo,   e_lo);
    chk({tag, "_zero"}, zero, e_zero);
    chk({tag, "_dbz"},  dbz,  e_dbz);
  endtask

  // Issue one op from mid-cycle; poke>=0 drives a stray ADD start that many cycles into busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int poke);
    int n;
    model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
    n = 0;
    if (e_lat > 0) chk({tag, "_busy_first"}, busy, 1'b1);
    while (!done && n < 100) begin
      if (n == poke) begin start = 1'b1; op = 2'b00; a = 1; b = 1; end
      step();
      start = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, n, e_lat);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk_outs(tag);
  endtask

  initial begin
    int seen;
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;

    rst_n = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    e_s = '0; e_hi = '0; e_lo = '0; e_zero = 1'b0; e_dbz = 1'b0; e_lat = 0;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk_outs("rst");
    rst_n = 1'b0;
    step();

    run_op("add7_5", 2'b00, 32'd7, 32'd5, -1);
    step();
    chk("add_done_pulse", done, 1'b0);

    run_op("sub5_5", 2'b01, 32'd5, 32'd5, -1);
    run_op("sub0_1", 2'b01, 32'd0, 32'd1, -1);

    run_op("mul_ff_2", 2'b10, 32'hFFFF_FFFF, 32'd2, 4);
    step();
    chk("mul_done_pulse", done, 1'b0);

    run_op("div100_7", 2'b11, 32'd100, 32'd7, -1);
    run_op("div6_7_b2b", 2'b11, 32'd6, 32'd7, -1);
    step();

    run_op("div_dbz", 2'b11, 32'h1234, 32'd0, -1);
    step();

    // Reset in the middle of a multiply.
    start = 1'b1; op = 2'b10; a = 32'd3; b = 32'd4;
    step();
    start = 1'b0;
    repeat (9) step();
    rst_n = 1'b1;
    #1;
    e_s = '0; e_hi = '0; e_lo = '0; e_zero = 1'b0; e_dbz = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk_outs("midrst");
    step();
    rst_n = 1'b0;
    seen = 0;
    repeat (40) begin
      step();
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    chk_outs("midrst_after");
    run_op("mul3_4", 2'b10, 32'd3, 32'd4, -1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: ry = $urandom_range(1, 15);
        2: rx = $urandom_range(0, 15);
        3: rx = '0;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), ro, rx, ry, -1);
      if ($urandom_range(0, 1) == 1) begin
        step();
        chk($sformatf("rnd%0d_pulse", i), done, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
